// File: rtl/gnn_pkg.sv
// gnn_pkg: shared definitions for the GNN activation pipeline.
//   - default activation width and batch geometry
//   - drain FSM state type
//   - flat_idx(): position of element (node, feat) in a flattened batch
package gnn_pkg;

  localparam int unsigned GnnDataW    = 21;
  localparam int unsigned GnnNumNodes = 4;
  localparam int unsigned GnnNumFeat  = 4;

  typedef enum logic [1:0] {
    StIdle,
    StSend,
    StDone
  } drain_state_e;

  // Element (node, feat) lives at slice node*num_feat+feat; element 0 is in the LSBs.
  function automatic int unsigned flat_idx(input int unsigned node, input int unsigned feat,
                                           input int unsigned num_feat);
    return node * num_feat + feat;
  endfunction

endpackage

// File: rtl/gnn_relu_drain_if.sv
// gnn_relu_drain_if: activation-buffer write port (valid/ready).
//   wr_valid  master->slave  beat valid
//   wr_ready  slave->master  sink accepts the beat
//   wr_addr   master->slave  beat address
//   wr_data   master->slave  beat data, signed
interface gnn_relu_drain_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = gnn_pkg::GnnDataW
);

  logic                     wr_valid;
  logic                     wr_ready;
  logic        [ADDR_W-1:0] wr_addr;
  logic signed [DATA_W-1:0] wr_data;

  modport master (
    output wr_valid,
    output wr_addr,
    output wr_data,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_addr,
    input  wr_data,
    output wr_ready
  );

endinterface

// File: rtl/gnn_relu_drain.sv
// gnn_relu_drain: consumer end of the ReLU stage handshake.
// Captures a NUM_NODES x NUM_FEAT activation batch on the rising edge of relu_ready_in and
// streams it, one element per accepted beat, to the activation-buffer write port.
//   clk, rst       clock; synchronous active-high reset
//   relu_ready_in  ReLU outputs valid (level); a rising edge is a new batch
//   in_data        flat batch, element 0 in the LSBs
//   base_addr      destination address of element 0, sampled at capture
//   wr             write port (master side)
//   busy           a batch is held or streaming
//   done           one-cycle pulse after the last beat is accepted
//   nz_count       non-zero elements in the last completed batch
//   overrun        sticky; a batch arrived while busy
module gnn_relu_drain
  import gnn_pkg::*;
#(
  parameter int unsigned DATA_W    = GnnDataW,
  parameter int unsigned NUM_NODES = GnnNumNodes,
  parameter int unsigned NUM_FEAT  = GnnNumFeat,
  parameter int unsigned ADDR_W    = 8
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  relu_ready_in,
  input  logic [NUM_NODES*NUM_FEAT*DATA_W-1:0] in_data,
  input  logic [ADDR_W-1:0]                     base_addr,
  gnn_relu_drain_if.master                      wr,
  output logic                                  busy,
  output logic                                  done,
  output logic [4:0]                            nz_count,
  output logic                                  overrun
);

  localparam int unsigned NumElem = NUM_NODES * NUM_FEAT;
  localparam int unsigned IdxW    = (NumElem > 1) ? $clog2(NumElem) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumElem - 1);

  drain_state_e r_state;
  drain_state_e w_state_next;

  logic                     r_rdy;
  logic signed [DATA_W-1:0] r_hold [NumElem];
  logic        [ADDR_W-1:0] r_base;
  logic        [IdxW-1:0]   r_idx;
  logic        [4:0]        r_nz_run;
  logic        [4:0]        r_nz_count;
  logic                     r_overrun;

  logic                     w_capture;
  logic                     w_valid;
  logic                     w_fire;
  logic                     w_last;
  logic                     w_nonzero;
  logic        [4:0]        w_nz_next;
  logic signed [DATA_W-1:0] w_cur_data;

  assign w_capture  = relu_ready_in & ~r_rdy;
  assign w_cur_data = r_hold[r_idx];
  assign w_fire     = w_valid & wr.wr_ready;
  assign w_last     = (r_idx == LastIdx);
  assign w_nonzero  = |w_cur_data;
  assign w_nz_next  = r_nz_run + 5'(w_nonzero);

  // Address and data are forced to zero outside SEND so every output is 0 out of reset,
  // before the hold registers have ever been loaded.
  assign wr.wr_valid = w_valid;
  assign wr.wr_addr  = w_valid ? (r_base + ADDR_W'(r_idx)) : '0;
  assign wr.wr_data  = w_valid ? w_cur_data : '0;

  assign nz_count = r_nz_count;
  assign overrun  = r_overrun;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_valid      = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_capture) begin
          w_state_next = StSend;
        end
      end
      StSend: begin
        w_valid = 1'b1;
        busy    = 1'b1;
        if (w_fire && w_last) begin
          w_state_next = StDone;
        end
      end
      StDone: begin
        done         = 1'b1;
        busy         = 1'b1;
        w_state_next = StIdle;
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  // Control and counters. rdy_q resets high so a level already present at reset release
  // is not mistaken for a new batch.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdy      <= 1'b1;
      r_base     <= '0;
      r_idx      <= '0;
      r_nz_run   <= '0;
      r_nz_count <= '0;
      r_overrun  <= 1'b0;
    end else begin
      r_rdy <= relu_ready_in;
      if (w_capture) begin
        if (r_state == StIdle) begin
          r_base   <= base_addr;
          r_idx    <= '0;
          r_nz_run <= '0;
        end else begin
          r_overrun <= 1'b1;
        end
      end
      if (w_fire) begin
        r_idx    <= w_last ? '0 : r_idx + 1'b1;
        r_nz_run <= w_nz_next;
        // Publish on the final accept so the new count is visible alongside done.
        if (w_last) begin
          r_nz_count <= w_nz_next;
        end
      end
    end
  end

  // Hold registers carry no reset; they are only read while streaming a captured batch.
  always_ff @(posedge clk) begin
    if ((r_state == StIdle) && w_capture) begin
      for (int unsigned n = 0; n < NUM_NODES; n++) begin
        for (int unsigned f = 0; f < NUM_FEAT; f++) begin
          r_hold[IdxW'(flat_idx(n, f, NUM_FEAT))] <=
            in_data[flat_idx(n, f, NUM_FEAT)*DATA_W +: DATA_W];
        end
      end
    end
  end

endmodule
